// File: rtl/disp_regs_pkg.sv
// -----------------------------------------------------------------------------
// disp_regs_pkg
// Shared definitions for the multi-layer display register block:
//   - register byte offsets (CTRL, INTEN, STAT, ERRCNT, DISPADDR base + stride)
//   - STAT bit indices
//   - be_merge(): byte-enable merge of a 32-bit write into an existing value
// -----------------------------------------------------------------------------
package disp_regs_pkg;

    localparam logic [11:0] OFF_CTRL        = 12'h000;
    localparam logic [11:0] OFF_INTEN       = 12'h004;
    localparam logic [11:0] OFF_STAT        = 12'h008;
    localparam logic [11:0] OFF_ERRCNT      = 12'h00C;
    localparam logic [11:0] OFF_DISPADDR    = 12'h100;
    localparam logic [11:0] DISPADDR_STRIDE = 12'h004;

    localparam int STAT_VBLANK = 0;
    localparam int STAT_UNDER  = 1;
    localparam int STAT_OVER   = 2;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = byteen[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/disp_shadow_reg.sv
// -----------------------------------------------------------------------------
// disp_shadow_reg
// Pending/active register pair for one layer's frame-buffer start address.
// The CPU writes the pending copy (byte enables honoured, bits above ADDR_W
// dropped); i_load copies pending into active. A write and a load in the same
// cycle give active the pre-write pending value.
// Ports:
//   ACLK, ARST   clock, synchronous active-high reset
//   i_wr_en      write strobe for the pending register
//   i_byteen     per-byte write enable
//   i_wdata      32-bit write data
//   i_load       copy pending -> active
//   o_pending    pending (shadow) value, used for readback
//   o_active     active value driven to the display pipeline
// -----------------------------------------------------------------------------
module disp_shadow_reg
    import disp_regs_pkg::*;
#(
    parameter int ADDR_W = 29
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              i_wr_en,
    input  logic [3:0]        i_byteen,
    input  logic [31:0]       i_wdata,
    input  logic              i_load,
    output logic [ADDR_W-1:0] o_pending,
    output logic [ADDR_W-1:0] o_active
);

    logic [ADDR_W-1:0] r_pending;
    logic [ADDR_W-1:0] r_active;

    // Pending/active register pair; load samples the old pending value.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_pending <= {ADDR_W{1'b0}};
            r_active  <= {ADDR_W{1'b0}};
        end else begin
            if (i_load) begin
                r_active <= r_pending;
            end
            if (i_wr_en) begin
                r_pending <= ADDR_W'(be_merge(32'(r_pending), i_wdata, i_byteen));
            end
        end
    end

    assign o_pending = r_pending;
    assign o_active  = r_active;

endmodule

// File: rtl/disp_regctrl_ml.sv
// -----------------------------------------------------------------------------
// disp_regctrl_ml
// CPU-side register file for a multi-layer display: control, interrupt enable,
// sticky status (VBLANK/UNDER/OVER, write-1-to-clear), per-layer frame-buffer
// start addresses shadowed to the VSYNC falling edge, registered readback.
// Optional build macro: DISP_ERRCNT_EN adds saturating 16-bit underrun/overrun
// counters at offset 0x00C (cleared by any write to that offset).
// Ports:
//   ACLK, ARST          clock, synchronous active-high reset
//   DSP_VSYNC_X         active-low VSYNC, synchronous to ACLK
//   WRADDR/BYTEEN/WREN/WDATA   write port ([15:12] block select)
//   RDADDR/RDEN/RDATA   read port, RDATA valid the cycle after RDEN
//   DISPON, LAYEREN     display / per-layer enables
//   DISPADDR            active start addresses, layer n at [n*ADDR_W +: ADDR_W]
//   DSP_IRQ             level interrupt = INTENBL & VBLANK (registered)
//   BUF_UNDER/BUF_OVER  FIFO error pulses
// -----------------------------------------------------------------------------
module disp_regctrl_ml
    import disp_regs_pkg::*;
#(
    parameter int         NUM_LAYERS = 2,
    parameter int         ADDR_W     = 29,
    parameter logic [3:0] BLOCK_ID   = 4'h0
) (
    input  logic                         ACLK,
    input  logic                         ARST,
    input  logic                         DSP_VSYNC_X,
    input  logic [15:0]                  WRADDR,
    input  logic [3:0]                   BYTEEN,
    input  logic                         WREN,
    input  logic [31:0]                  WDATA,
    input  logic [15:0]                  RDADDR,
    input  logic                         RDEN,
    output logic [31:0]                  RDATA,
    output logic                         DISPON,
    output logic [NUM_LAYERS-1:0]        LAYEREN,
    output logic [NUM_LAYERS*ADDR_W-1:0] DISPADDR,
    output logic                         DSP_IRQ,
    input  logic                         BUF_UNDER,
    input  logic                         BUF_OVER
);

    logic                  r_vsync_prev;
    logic                  w_vs_fall;
    logic                  w_wr_hit;
    logic [11:0]           w_wr_off;
    logic                  w_rd_hit;
    logic                  r_dispon;
    logic [NUM_LAYERS-1:0] r_layeren;
    logic                  r_intenbl;
    logic [2:0]            r_stat;
    logic [2:0]            w_stat_set;
    logic [2:0]            w_stat_clr;
    logic                  r_irq;
    logic [31:0]           r_rdata;
    logic [31:0]           w_ctrl_rd;
    logic [31:0]           w_errcnt_rd;
    logic [31:0]           w_rd_val;
    logic [NUM_LAYERS-1:0] w_addr_we;
    logic [ADDR_W-1:0]     w_pending [NUM_LAYERS];

    assign w_wr_hit  = WREN & (WRADDR[15:12] == BLOCK_ID);
    assign w_wr_off  = WRADDR[11:0];
    assign w_vs_fall = r_vsync_prev & ~DSP_VSYNC_X;

    // VSYNC edge register; resets high so reset itself never looks like a fall.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_vsync_prev <= 1'b1;
        end else begin
            r_vsync_prev <= DSP_VSYNC_X;
        end
    end

    // CTRL and INTEN registers, effective the cycle after the write.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_dispon  <= 1'b0;
            r_layeren <= {NUM_LAYERS{1'b0}};
            r_intenbl <= 1'b0;
        end else begin
            if (w_wr_hit && (w_wr_off == OFF_CTRL)) begin
                if (BYTEEN[0]) begin
                    r_dispon <= WDATA[0];
                end
                if (BYTEEN[1]) begin
                    r_layeren <= WDATA[8 +: NUM_LAYERS];
                end
            end
            if (w_wr_hit && (w_wr_off == OFF_INTEN) && BYTEEN[0]) begin
                r_intenbl <= WDATA[0];
            end
        end
    end

    // STAT set sources and write-1-to-clear mask.
    always_comb begin
        w_stat_set              = 3'b000;
        w_stat_set[STAT_VBLANK] = w_vs_fall;
        w_stat_set[STAT_UNDER]  = BUF_UNDER;
        w_stat_set[STAT_OVER]   = BUF_OVER;
        if (w_wr_hit && (w_wr_off == OFF_STAT) && BYTEEN[0]) begin
            w_stat_clr = WDATA[2:0];
        end else begin
            w_stat_clr = 3'b000;
        end
    end

    // Sticky STAT; ORing the set term last makes a coincident set win over W1C.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_stat <= 3'b000;
        end else begin
            r_stat <= (r_stat & ~w_stat_clr) | w_stat_set;
        end
    end

    // Registered interrupt level, one cycle behind VBLANK/INTENBL.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_intenbl & r_stat[STAT_VBLANK];
        end
    end

`ifdef DISP_ERRCNT_EN
    logic [15:0] r_under_cnt;
    logic [15:0] r_over_cnt;
    logic        w_errcnt_clr;

    assign w_errcnt_clr = w_wr_hit & (w_wr_off == OFF_ERRCNT);

    // Saturating error counters; a clear drops any pulse arriving with it.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_under_cnt <= 16'h0000;
            r_over_cnt  <= 16'h0000;
        end else if (w_errcnt_clr) begin
            r_under_cnt <= 16'h0000;
            r_over_cnt  <= 16'h0000;
        end else begin
            if (BUF_UNDER && (r_under_cnt != 16'hFFFF)) begin
                r_under_cnt <= r_under_cnt + 16'h0001;
            end
            if (BUF_OVER && (r_over_cnt != 16'hFFFF)) begin
                r_over_cnt <= r_over_cnt + 16'h0001;
            end
        end
    end

    assign w_errcnt_rd = {r_over_cnt, r_under_cnt};
`else
    assign w_errcnt_rd = 32'h0000_0000;
`endif

    // Per-layer shadowed start address.
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        localparam logic [11:0] LP_OFF = OFF_DISPADDR + DISPADDR_STRIDE * 12'(g);

        assign w_addr_we[g] = w_wr_hit & (w_wr_off == LP_OFF);

        disp_shadow_reg #(
            .ADDR_W (ADDR_W)
        ) u_shadow (
            .ACLK      (ACLK),
            .ARST      (ARST),
            .i_wr_en   (w_addr_we[g]),
            .i_byteen  (BYTEEN),
            .i_wdata   (WDATA),
            .i_load    (w_vs_fall),
            .o_pending (w_pending[g]),
            .o_active  (DISPADDR[g*ADDR_W +: ADDR_W])
        );
    end

    // CTRL readback image.
    always_comb begin
        w_ctrl_rd                  = 32'h0000_0000;
        w_ctrl_rd[0]               = r_dispon;
        w_ctrl_rd[8 +: NUM_LAYERS] = r_layeren;
    end

    // Read decode; DISPADDR reads return the pending value.
    always_comb begin
        w_rd_hit = RDEN & (RDADDR[15:12] == BLOCK_ID);
        case (RDADDR[11:0])
            OFF_CTRL:   w_rd_val = w_ctrl_rd;
            OFF_INTEN:  w_rd_val = {31'h0000_0000, r_intenbl};
            OFF_STAT:   w_rd_val = {29'h0000_0000, r_stat};
            OFF_ERRCNT: w_rd_val = w_errcnt_rd;
            default:    w_rd_val = 32'h0000_0000;
        endcase
        for (int n = 0; n < NUM_LAYERS; n++) begin
            if (RDADDR[11:0] == (OFF_DISPADDR + DISPADDR_STRIDE * 12'(n))) begin
                w_rd_val = 32'(w_pending[n]);
            end else begin
                w_rd_val = w_rd_val;
            end
        end
    end

    // Read data register, held until the next RDEN; foreign-block reads give 0.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_rdata <= 32'h0000_0000;
        end else if (RDEN) begin
            r_rdata <= w_rd_hit ? w_rd_val : 32'h0000_0000;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign RDATA   = r_rdata;
    assign DISPON  = r_dispon;
    assign LAYEREN = r_layeren;
    assign DSP_IRQ = r_irq;

endmodule

// File: tb/tb_disp_regctrl_ml.sv
module tb_disp_regctrl_ml;

    localparam int NL = 2;
    localparam int AW = 29;

    logic          ACLK = 1'b0;
    logic          ARST;
    logic          DSP_VSYNC_X;
    logic [15:0]   WRADDR;
    logic [3:0]    BYTEEN;
    logic          WREN;
    logic [31:0]   WDATA;
    logic [15:0]   RDADDR;
    logic          RDEN;
    logic [31:0]   RDATA;
    logic          DISPON;
    logic [NL-1:0] LAYEREN;
    logic [NL*AW-1:0] DISPADDR;
    logic          DSP_IRQ;
    logic          BUF_UNDER;
    logic          BUF_OVER;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd;
    logic [31:0] errcnt_exp;

    disp_regctrl_ml #(
        .NUM_LAYERS (NL),
        .ADDR_W     (AW),
        .BLOCK_ID   (4'h0)
    ) dut (
        .ACLK        (ACLK),
        .ARST        (ARST),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .WRADDR      (WRADDR),
        .BYTEEN      (BYTEEN),
        .WREN        (WREN),
        .WDATA       (WDATA),
        .RDADDR      (RDADDR),
        .RDEN        (RDEN),
        .RDATA       (RDATA),
        .DISPON      (DISPON),
        .LAYEREN     (LAYEREN),
        .DISPADDR    (DISPADDR),
        .DSP_IRQ     (DSP_IRQ),
        .BUF_UNDER   (BUF_UNDER),
        .BUF_OVER    (BUF_OVER)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
        step();
        WREN = 1'b0; BYTEEN = 4'h0;
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [31:0] d);
        RDADDR = a; RDEN = 1'b1;
        step();
        RDEN = 1'b0;
        d = RDATA;
    endtask

    task automatic vs_pulse();
        DSP_VSYNC_X = 1'b0;
        step();
        DSP_VSYNC_X = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [15:0] addrs [4];
        addrs[0] = 16'h0000; addrs[1] = 16'h0004; addrs[2] = 16'h0008; addrs[3] = 16'h0100;
        ARST = 1'b1; DSP_VSYNC_X = 1'b1; WREN = 1'b0; RDEN = 1'b0; BYTEEN = 4'h0;
        WRADDR = 16'h0000; WDATA = 32'h0; RDADDR = 16'h0000; BUF_UNDER = 1'b0; BUF_OVER = 1'b0;
        repeat (3) step();
        ARST = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            rd_reg(addrs[i], rd);
            n_cmp++;
            if (rd !== 32'h0) begin
                n_bad++; $display("FAIL reset_rd[%h]: got %h want %h", addrs[i], rd, 32'h0);
            end
        end
        n_cmp++;
        if (DSP_IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", DSP_IRQ); end
        n_cmp++;
        if ({DISPON, LAYEREN, DISPADDR} !== {(1+NL+NL*AW){1'b0}}) begin
            n_bad++; $display("FAIL reset_outs: dispon %b layeren %b dispaddr %h", DISPON, LAYEREN, DISPADDR);
        end
    endtask

    task automatic test_shadow();
        wr(16'h0100, 32'h0123_4567, 4'b0011);
        rd_reg(16'h0100, rd);
        n_cmp++;
        if (rd !== 32'h0000_4567) begin n_bad++; $display("FAIL shadow_rb0: got %h want %h", rd, 32'h0000_4567); end
        n_cmp++;
        if (DISPADDR[28:0] !== 29'h0) begin n_bad++; $display("FAIL shadow_pre0: got %h want 0", DISPADDR[28:0]); end
        vs_pulse();
        n_cmp++;
        if (DISPADDR[28:0] !== 29'h4567) begin n_bad++; $display("FAIL shadow_post0: got %h want %h", DISPADDR[28:0], 29'h4567); end
        n_cmp++;
        if (DISPADDR[57:29] !== 29'h0) begin n_bad++; $display("FAIL shadow_l1_idle: got %h want 0", DISPADDR[57:29]); end
        wr(16'h0104, 32'hFFFF_FFFF, 4'hF);
        rd_reg(16'h0104, rd);
        n_cmp++;
        if (rd !== 32'h1FFF_FFFF) begin n_bad++; $display("FAIL shadow_trunc: got %h want %h", rd, 32'h1FFF_FFFF); end
        vs_pulse();
        n_cmp++;
        if (DISPADDR[57:29] !== 29'h1FFF_FFFF) begin n_bad++; $display("FAIL shadow_post1: got %h want %h", DISPADDR[57:29], 29'h1FFF_FFFF); end
    endtask

    task automatic test_coincident();
        WRADDR = 16'h0104; WDATA = 32'h0AAA_AAAA; BYTEEN = 4'hF; WREN = 1'b1; DSP_VSYNC_X = 1'b0;
        step();
        WREN = 1'b0; BYTEEN = 4'h0; DSP_VSYNC_X = 1'b1;
        n_cmp++;
        if (DISPADDR[57:29] !== 29'h1FFF_FFFF) begin n_bad++; $display("FAIL coinc_old: got %h want %h", DISPADDR[57:29], 29'h1FFF_FFFF); end
        step();
        rd_reg(16'h0104, rd);
        n_cmp++;
        if (rd !== 32'h0AAA_AAAA) begin n_bad++; $display("FAIL coinc_pend: got %h want %h", rd, 32'h0AAA_AAAA); end
        vs_pulse();
        n_cmp++;
        if (DISPADDR[57:29] !== 29'h0AAA_AAAA) begin n_bad++; $display("FAIL coinc_new: got %h want %h", DISPADDR[57:29], 29'h0AAA_AAAA); end
        n_cmp++;
        if (DISPADDR[28:0] !== 29'h4567) begin n_bad++; $display("FAIL coinc_l0: got %h want %h", DISPADDR[28:0], 29'h4567); end
    endtask

    task automatic test_irq();
        wr(16'h0008, 32'h7, 4'hF);
        wr(16'h0004, 32'h1, 4'h1);
        DSP_VSYNC_X = 1'b0;
        step();
        DSP_VSYNC_X = 1'b1;
        n_cmp++;
        if (DSP_IRQ !== 1'b0) begin n_bad++; $display("FAIL irq_lat: got %b want 0", DSP_IRQ); end
        step();
        n_cmp++;
        if (DSP_IRQ !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", DSP_IRQ); end
        rd_reg(16'h0008, rd);
        n_cmp++;
        if (rd !== 32'h1) begin n_bad++; $display("FAIL irq_stat: got %h want %h", rd, 32'h1); end
        wr(16'h0008, 32'h1, 4'h1);
        n_cmp++;
        if (DSP_IRQ !== 1'b1) begin n_bad++; $display("FAIL irq_w1c_lat: got %b want 1", DSP_IRQ); end
        step();
        n_cmp++;
        if (DSP_IRQ !== 1'b0) begin n_bad++; $display("FAIL irq_w1c: got %b want 0", DSP_IRQ); end
        WRADDR = 16'h0008; WDATA = 32'h1; BYTEEN = 4'h1; WREN = 1'b1; DSP_VSYNC_X = 1'b0;
        step();
        WREN = 1'b0; BYTEEN = 4'h0; DSP_VSYNC_X = 1'b1;
        rd_reg(16'h0008, rd);
        n_cmp++;
        if (rd !== 32'h1) begin n_bad++; $display("FAIL irq_setwins: got %h want %h", rd, 32'h1); end
        wr(16'h0004, 32'h0, 4'h1);
        step();
        n_cmp++;
        if (DSP_IRQ !== 1'b0) begin n_bad++; $display("FAIL irq_inten_off: got %b want 0", DSP_IRQ); end
        wr(16'h0008, 32'h7, 4'hF);
    endtask

    task automatic test_ctrl();
        wr(16'h0000, 32'h0000_0301, 4'hF);
        n_cmp++;
        if ({DISPON, LAYEREN} !== 3'b111) begin n_bad++; $display("FAIL ctrl_set: got %b want 111", {DISPON, LAYEREN}); end
        rd_reg(16'h0000, rd);
        n_cmp++;
        if (rd !== 32'h0000_0301) begin n_bad++; $display("FAIL ctrl_rb: got %h want %h", rd, 32'h0000_0301); end
        wr(16'h0000, 32'h0, 4'b0001);
        n_cmp++;
        if ({DISPON, LAYEREN} !== 3'b011) begin n_bad++; $display("FAIL ctrl_be0: got %b want 011", {DISPON, LAYEREN}); end
        wr(16'h0000, 32'h0000_0101, 4'hF);
        n_cmp++;
        if ({DISPON, LAYEREN} !== 3'b101) begin n_bad++; $display("FAIL ctrl_l1off: got %b want 101", {DISPON, LAYEREN}); end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 3; i++) begin
            BUF_UNDER = 1'b1; step(); BUF_UNDER = 1'b0; step();
        end
        BUF_OVER = 1'b1; step(); BUF_OVER = 1'b0; step();
        rd_reg(16'h0008, rd);
        n_cmp++;
        if (rd !== 32'h6) begin n_bad++; $display("FAIL err_stat: got %h want %h", rd, 32'h6); end
`ifdef DISP_ERRCNT_EN
        errcnt_exp = 32'h0001_0003;
`else
        errcnt_exp = 32'h0;
`endif
        rd_reg(16'h000C, rd);
        n_cmp++;
        if (rd !== errcnt_exp) begin n_bad++; $display("FAIL err_cnt: got %h want %h", rd, errcnt_exp); end
        wr(16'h000C, 32'h0, 4'hF);
        rd_reg(16'h000C, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL err_cnt_clr: got %h want %h", rd, 32'h0); end
        WRADDR = 16'h0008; WDATA = 32'h2; BYTEEN = 4'h1; WREN = 1'b1; BUF_UNDER = 1'b1;
        step();
        WREN = 1'b0; BYTEEN = 4'h0; BUF_UNDER = 1'b0;
        rd_reg(16'h0008, rd);
        n_cmp++;
        if (rd !== 32'h6) begin n_bad++; $display("FAIL err_setwins: got %h want %h", rd, 32'h6); end
        wr(16'h0008, 32'h4, 4'h1);
        rd_reg(16'h0008, rd);
        n_cmp++;
        if (rd !== 32'h2) begin n_bad++; $display("FAIL err_w1c_over: got %h want %h", rd, 32'h2); end
        wr(16'h0008, 32'h7, 4'h1);
    endtask

    task automatic test_other_block();
        rd_reg(16'h0100, rd);
        n_cmp++;
        if (rd !== 32'h0000_4567) begin n_bad++; $display("FAIL ob_rd_own: got %h want %h", rd, 32'h0000_4567); end
        rd_reg(16'h1100, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL ob_rd_foreign: got %h want 0", rd); end
        wr(16'h1100, 32'h1234_5678, 4'hF);
        wr(16'h1000, 32'h0, 4'hF);
        n_cmp++;
        if ({DISPON, LAYEREN} !== 3'b101) begin n_bad++; $display("FAIL ob_ctrl: got %b want 101", {DISPON, LAYEREN}); end
        rd_reg(16'h0100, rd);
        n_cmp++;
        if (rd !== 32'h0000_4567) begin n_bad++; $display("FAIL ob_pend: got %h want %h", rd, 32'h0000_4567); end
        rd_reg(16'h0010, rd);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL ob_unmapped: got %h want 0", rd); end
        rd_reg(16'h0104, rd);
        repeat (2) step();
        n_cmp++;
        if (RDATA !== 32'h0AAA_AAAA) begin n_bad++; $display("FAIL ob_hold: got %h want %h", RDATA, 32'h0AAA_AAAA); end
        vs_pulse();
        n_cmp++;
        if (DISPADDR[28:0] !== 29'h4567) begin n_bad++; $display("FAIL ob_active: got %h want %h", DISPADDR[28:0], 29'h4567); end
    endtask

    task automatic test_reset_mid();
        wr(16'h0100, 32'h00AB_CDEF, 4'hF);
        ARST = 1'b1;
        step();
        ARST = 1'b0;
        n_cmp++;
        if ({DISPON, LAYEREN, DSP_IRQ, RDATA} !== {(1+NL+1+32){1'b0}}) begin
            n_bad++; $display("FAIL rst_mid_outs: dispon %b layeren %b irq %b rdata %h", DISPON, LAYEREN, DSP_IRQ, RDATA);
        end
        vs_pulse();
        n_cmp++;
        if (DISPADDR !== {(NL*AW){1'b0}}) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 0", DISPADDR); end
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_coincident();
        test_irq();
        test_ctrl();
        test_errors();
        test_other_block();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
